// File: rtl/dht11_reader_pkg.sv
// Shared definitions for the DHT11 reader: FSM state encodings, err_code values
// and the frame checksum helper.
package dht11_reader_pkg;

   typedef logic [23:0] us_cnt_t;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_START_LOW = 4'd1,
      ST_WAIT_RESP = 4'd2,
      ST_RESP_LOW  = 4'd3,
      ST_RESP_HIGH = 4'd4,
      ST_BIT_LOW   = 4'd5,
      ST_BIT_HIGH  = 4'd6,
      ST_CHECK     = 4'd7,
      ST_COOLDOWN  = 4'd8
   } dht_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_NO_RESP  = 2'd1;
   localparam logic [1:0] ERR_BIT_TMO  = 2'd2;
   localparam logic [1:0] ERR_CHECKSUM = 2'd3;

   // Byte sum of the four payload bytes, modulo 256.
   function automatic logic [7:0] frame_sum(input logic [39:0] frame);
      return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
   endfunction

endpackage

// File: rtl/dht11_reader_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_HZ/1000000 hclk cycles.
module us_tick #(
   parameter int CLK_HZ = 12000000
) (
   input  logic hclk,
   input  logic rst,
   output logic tick
);
   localparam int DIV = CLK_HZ / 1000000;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;
   logic          tick_r;

   // Divider counter with a registered tick on wrap.
   always_ff @(posedge hclk) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else if (cnt_r == LAST) begin
         cnt_r  <= '0;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CW'(1);
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: start pulse, response/bit timing, 40-bit capture,
// checksum verification and post-read cooldown.
module dht11_reader
   import dht11_reader_pkg::*;
#(
   parameter int CLK_HZ        = 12000000,
   parameter int START_LOW_US  = 18000,
   parameter int TIMEOUT_US    = 100,
   parameter int BIT_THRESH_US = 40,
   parameter int COOLDOWN_US   = 1000000
) (
   input  logic       hclk,
   input  logic       rst,
   input  logic       start,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic [7:0] humedad,
   output logic [7:0] temperatura,
   output logic       valid,
   output logic       err,
   output logic [1:0] err_code,
   output logic       ready
);
   localparam us_cnt_t START_LOW_T  = us_cnt_t'(START_LOW_US);
   localparam us_cnt_t TIMEOUT_T    = us_cnt_t'(TIMEOUT_US);
   localparam us_cnt_t BIT_THRESH_T = us_cnt_t'(BIT_THRESH_US);
   localparam us_cnt_t COOLDOWN_T   = us_cnt_t'(COOLDOWN_US);

   dht_state_t  state_r, state_next_s;
   logic        tick_s;
   logic        din_meta_r, din_sync_r, din_prev_r;
   logic        din_fall_s, tmo_s, bit_val_s;
   us_cnt_t     us_cnt_r, us_next_s;
   logic [39:0] frame_r;
   logic [5:0]  bit_idx_r;
   logic        clear_s, shift_s, valid_s, err_s;
   logic [1:0]  code_s;
   logic        dht_oe_r, valid_r, err_r, ready_r;
   logic [7:0]  humedad_r, temperatura_r;
   logic [1:0]  err_code_r;

   us_tick #(.CLK_HZ(CLK_HZ)) u_us_tick (
      .hclk (hclk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge hclk) begin
      if (rst) begin
         din_meta_r <= 1'b1;
         din_sync_r <= 1'b1;
         din_prev_r <= 1'b1;
      end else begin
         din_meta_r <= dht_in;
         din_sync_r <= din_meta_r;
         din_prev_r <= din_sync_r;
      end
   end

   // us_next_s is the elapsed phase time at the end of this cycle, so every
   // threshold below compares against whole microseconds already spent.
   assign us_next_s  = (tick_s && (us_cnt_r != '1)) ? us_cnt_r + us_cnt_t'(1) : us_cnt_r;
   assign tmo_s      = (us_next_s > TIMEOUT_T);
   assign bit_val_s  = (us_next_s > BIT_THRESH_T);
   // WAIT_RESP needs an edge: the synchronizer still shows our own start pulse.
   assign din_fall_s = din_prev_r & ~din_sync_r;

   // Next-state and per-read result decode.
   always_comb begin
      state_next_s = state_r;
      clear_s      = 1'b0;
      shift_s      = 1'b0;
      valid_s      = 1'b0;
      err_s        = 1'b0;
      code_s       = err_code_r;
      case (state_r)
         ST_IDLE: begin
            if (start && ready_r) begin
               state_next_s = ST_START_LOW;
               clear_s      = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_START_LOW: begin
            if (us_next_s == START_LOW_T) state_next_s = ST_WAIT_RESP;
            else                          state_next_s = ST_START_LOW;
         end
         ST_WAIT_RESP: begin
            if (din_fall_s) begin
               state_next_s = ST_RESP_LOW;
            end else if (tmo_s) begin
               state_next_s = ST_COOLDOWN;
               err_s        = 1'b1;
               code_s       = ERR_NO_RESP;
            end else begin
               state_next_s = ST_WAIT_RESP;
            end
         end
         ST_RESP_LOW: begin
            if (din_sync_r) begin
               state_next_s = ST_RESP_HIGH;
            end else if (tmo_s) begin
               state_next_s = ST_COOLDOWN;
               err_s        = 1'b1;
               code_s       = ERR_NO_RESP;
            end else begin
               state_next_s = ST_RESP_LOW;
            end
         end
         ST_RESP_HIGH: begin
            if (!din_sync_r) begin
               state_next_s = ST_BIT_LOW;
            end else if (tmo_s) begin
               state_next_s = ST_COOLDOWN;
               err_s        = 1'b1;
               code_s       = ERR_NO_RESP;
            end else begin
               state_next_s = ST_RESP_HIGH;
            end
         end
         ST_BIT_LOW: begin
            if (din_sync_r) begin
               state_next_s = ST_BIT_HIGH;
            end else if (tmo_s) begin
               state_next_s = ST_COOLDOWN;
               err_s        = 1'b1;
               code_s       = ERR_BIT_TMO;
            end else begin
               state_next_s = ST_BIT_LOW;
            end
         end
         ST_BIT_HIGH: begin
            if (!din_sync_r) begin
               shift_s = 1'b1;
               if (bit_idx_r == 6'd39) state_next_s = ST_CHECK;
               else                    state_next_s = ST_BIT_LOW;
            end else if (tmo_s) begin
               state_next_s = ST_COOLDOWN;
               err_s        = 1'b1;
               code_s       = ERR_BIT_TMO;
            end else begin
               state_next_s = ST_BIT_HIGH;
            end
         end
         ST_CHECK: begin
            state_next_s = ST_COOLDOWN;
            if (frame_sum(frame_r) == frame_r[7:0]) begin
               valid_s = 1'b1;
               code_s  = ERR_NONE;
            end else begin
               err_s   = 1'b1;
               code_s  = ERR_CHECKSUM;
            end
         end
         ST_COOLDOWN: begin
            if (us_next_s == COOLDOWN_T) state_next_s = ST_IDLE;
            else                         state_next_s = ST_COOLDOWN;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register and phase timer, cleared on every state change.
   always_ff @(posedge hclk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         us_cnt_r <= '0;
      end else begin
         state_r  <= state_next_s;
         us_cnt_r <= (state_next_s != state_r) ? '0 : us_next_s;
      end
   end

   // MSB-first capture of the 40-bit frame.
   always_ff @(posedge hclk) begin
      if (rst || clear_s) begin
         frame_r   <= '0;
         bit_idx_r <= '0;
      end else if (shift_s) begin
         frame_r   <= {frame_r[38:0], bit_val_s};
         bit_idx_r <= bit_idx_r + 6'd1;
      end
   end

   // Registered outputs; data bytes only move on a good checksum.
   always_ff @(posedge hclk) begin
      if (rst) begin
         dht_oe_r      <= 1'b0;
         ready_r       <= 1'b1;
         valid_r       <= 1'b0;
         err_r         <= 1'b0;
         err_code_r    <= ERR_NONE;
         humedad_r     <= 8'd0;
         temperatura_r <= 8'd0;
      end else begin
         dht_oe_r   <= (state_next_s == ST_START_LOW);
         ready_r    <= (state_next_s == ST_IDLE);
         valid_r    <= valid_s;
         err_r      <= err_s;
         err_code_r <= code_s;
         if (valid_s) begin
            humedad_r     <= frame_r[39:32];
            temperatura_r <= frame_r[23:16];
         end
      end
   end

   assign dht_oe      = dht_oe_r;
   assign ready       = ready_r;
   assign valid       = valid_r;
   assign err         = err_r;
   assign err_code    = err_code_r;
   assign humedad     = humedad_r;
   assign temperatura = temperatura_r;

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a behavioural DHT11 on a pulled-up wire.
// hclk is 1 MHz so one cycle is one microsecond.
`timescale 1ns/1ps
module tb_dht11_reader;
   // Start pulse shortened from 18000 us to keep the run short; it is still
   // checked for exact length.
   localparam int START_US = 6000;

   logic       hclk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sensor_low = 1'b0;
   logic       dht_in;
   logic       dht_oe;
   logic [7:0] humedad, temperatura;
   logic       valid, err, ready;
   logic [1:0] err_code;

   int          total = 0, bad = 0;
   int          mode = 0;
   logic [39:0] frame_v = 40'd0;
   int          h0 = 26, h1 = 70;
   int          cyc = 0, n_valid = 0, n_err = 0, n_both = 0, n_pulses = 0;
   int          oe_len = 0, last_oe_len = 0, t_rel = 0, t_err = 0;
   logic        oe_prev = 1'b0;
   int          pv, pe, pp, cnt;

   assign dht_in = ~(dht_oe | sensor_low);

   dht11_reader #(
      .CLK_HZ(1000000), .START_LOW_US(START_US), .TIMEOUT_US(100),
      .BIT_THRESH_US(40), .COOLDOWN_US(50)
   ) dut (
      .hclk(hclk), .rst(rst), .start(start), .dht_in(dht_in), .dht_oe(dht_oe),
      .humedad(humedad), .temperatura(temperatura), .valid(valid), .err(err),
      .err_code(err_code), .ready(ready)
   );

   always #500 hclk = ~hclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Event monitor sampled on the inactive edge.
   always @(negedge hclk) begin
      cyc++;
      if (valid) n_valid++;
      if (err) begin n_err++; t_err = cyc; end
      if (valid && err) n_both++;
      if (dht_oe) begin
         if (!oe_prev) n_pulses++;
         oe_len++;
      end else begin
         if (oe_prev) begin last_oe_len = oe_len; t_rel = cyc; end
         oe_len = 0;
      end
      oe_prev = dht_oe;
   end

   task automatic hold(input int n, input logic lvl);
      sensor_low = lvl;
      repeat (n) @(negedge hclk);
   endtask

   // Sensor model: mode 0 silent, 1 full frame, 2 freeze high in bit 17.
   initial begin
      forever begin
         @(negedge dht_oe);
         if (mode != 0) begin
            logic stuck;
            stuck = 1'b0;
            hold(30, 1'b0);
            hold(80, 1'b1);
            hold(80, 1'b0);
            for (int i = 39; i >= 0; i--) begin
               hold(50, 1'b1);
               if (mode == 2 && i == 23) begin
                  stuck = 1'b1;
                  sensor_low = 1'b0;
                  break;
               end
               hold(frame_v[i] ? h1 : h0, 1'b0);
            end
            if (!stuck) hold(50, 1'b1);
            sensor_low = 1'b0;
         end
      end
   end

   task automatic do_start();
      @(negedge hclk);
      start = 1'b1;
      @(negedge hclk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 30000; k++) begin
         @(negedge hclk);
         #1;
         if (valid || err) begin seen = 1'b1; break; end
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_ready(input string tag);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge hclk);
         if (ready) begin seen = 1'b1; break; end
      end
      check_eq(tag, 32'(seen), 32'd1);
      repeat (5) @(negedge hclk);
   endtask

   initial begin
      #150000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge hclk);
      check_eq("rst_state", 32'({dht_oe, humedad, temperatura, valid, err, err_code, ready}), 32'h1);
      rst = 1'b0;
      repeat (2) @(negedge hclk);

      // Good frame, with a start poked while busy and another during cooldown.
      mode = 1; frame_v = 40'h37_00_19_00_50; h0 = 26; h1 = 70;
      pv = n_valid; pe = n_err; pp = n_pulses;
      do_start();
      repeat (100) @(negedge hclk);
      start = 1'b1;
      @(negedge hclk);
      start = 1'b0;
      wait_done("good_done");
      check_eq("good_valid", 32'(valid), 32'd1);
      check_eq("good_hum", 32'(humedad), 32'd55);
      check_eq("good_temp", 32'(temperatura), 32'd25);
      check_eq("good_code", 32'(err_code), 32'd0);
      check_eq("good_oe_len", 32'(last_oe_len), 32'(START_US));
      cnt = 0;
      while (!ready && cnt < 200) begin
         start = (cnt == 10);
         cnt++;
         @(negedge hclk);
         #1;
      end
      start = 1'b0;
      check_eq("cooldown_len", 32'(cnt), 32'd50);
      repeat (30) @(negedge hclk);
      check_eq("no_requeue", 32'(n_pulses - pp), 32'd1);
      check_eq("good_nvalid", 32'(n_valid - pv), 32'd1);
      check_eq("good_nerr", 32'(n_err - pe), 32'd0);

      // Bad checksum keeps previous data.
      frame_v = 40'h37_00_19_00_51;
      pv = n_valid;
      do_start();
      wait_done("chk_done");
      check_eq("chk_err", 32'(err), 32'd1);
      check_eq("chk_code", 32'(err_code), 32'd3);
      check_eq("chk_data", 32'({humedad, temperatura}), 32'h3719);
      check_eq("chk_nvalid", 32'(n_valid - pv), 32'd0);
      wait_ready("chk_ready");

      // No sensor: timeout 101 us after release.
      mode = 0;
      pv = n_valid;
      do_start();
      wait_done("nores_done");
      check_eq("nores_code", 32'(err_code), 32'd1);
      check_eq("nores_delay", 32'(t_err - t_rel), 32'd101);
      check_eq("nores_nvalid", 32'(n_valid - pv), 32'd0);
      wait_ready("nores_ready");

      // Stuck high during bit 17.
      mode = 2; frame_v = 40'h37_00_19_00_50;
      do_start();
      wait_done("stuck_done");
      check_eq("stuck_err", 32'(err), 32'd1);
      check_eq("stuck_code", 32'(err_code), 32'd2);
      check_eq("stuck_oe", 32'(dht_oe), 32'd0);
      check_eq("stuck_data", 32'({humedad, temperatura}), 32'h3719);
      wait_ready("stuck_ready");

      // Recovery read with 39/41 us high phases at the bit threshold.
      mode = 1; frame_v = 40'h41_00_17_00_58; h0 = 39; h1 = 41;
      do_start();
      wait_done("thr_done");
      check_eq("thr_valid", 32'(valid), 32'd1);
      check_eq("thr_data", 32'({humedad, temperatura}), 32'h4117);
      check_eq("thr_code", 32'(err_code), 32'd0);
      wait_ready("thr_ready");

      // Reset 5000 us into the start pulse.
      mode = 0;
      pv = n_valid; pe = n_err;
      do_start();
      repeat (5000) @(negedge hclk);
      rst = 1'b1;
      @(posedge hclk);
      #1;
      check_eq("rst_mid_outs", 32'({dht_oe, humedad, temperatura, valid, err, err_code}), 32'd0);
      check_eq("rst_mid_ready", 32'(ready), 32'd1);
      @(negedge hclk);
      rst = 1'b0;
      start = 1'b1;
      @(negedge hclk);
      start = 1'b0;
      check_eq("rst_no_pulse", 32'((n_valid - pv) + (n_err - pe)), 32'd0);

      // Start right after reset: full pulse, then no-response error.
      wait_done("rar_done");
      check_eq("rar_oe_len", 32'(last_oe_len), 32'(START_US));
      check_eq("rar_code", 32'(err_code), 32'd1);

      check_eq("never_both", 32'(n_both), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
